mem_io_target: RTL

- Bus responder for the CPU's memory interface. It takes the CPU's address, write-enable and write-data, and returns read data.
- Read data is combinational within the same cycle, because the CPU feeds read data straight back into its next address. Writes are synchronous.
- Contains byte-wide RAM at the bottom of the address space.
- Contains an I/O page with an interval timer (interrupt flag) and a byte output port with a valid/ready handshake toward an external sink.

---
 rtl/mem_io_target_if.sv | 22 ++
 rtl/mem_io_target.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_target_if.sv
// CPU memory bus plus byte output port toward an external sink.
// The CPU side (master) drives address/strobe/data; the target (slave) returns read data and port status.
interface mem_io_target_if;
  logic [15:0] Address;
  logic        WE;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;
  logic        IRQ;
  logic        OUT_VALID;
  logic [7:0]  OUT_DATA;
  logic        OUT_READY;

  modport master (
    output Address, WE, DataIn, OUT_READY,
    input  DataOut, IRQ, OUT_VALID, OUT_DATA
  );

  modport slave (
    input  Address, WE, DataIn, OUT_READY,
    output DataOut, IRQ, OUT_VALID, OUT_DATA
  );
endinterface

// File: rtl/mem_io_target.sv
// Memory/I-O responder: byte RAM at the bottom of the map, an I/O page with an output port and,
// when MEM_IO_TARGET_TIMER_EN is defined, an interval timer with prescaler and registered IRQ.
module mem_io_target #(
  parameter int unsigned RAM_AW   = 10,
  parameter logic [7:0]  IO_PAGE  = 8'hFE,
  parameter int unsigned PRESCALE = 1
) (
  input  logic           CLK,
  input  logic           R_N,
  mem_io_target_if.slave bus
);

  localparam int unsigned RAM_DEPTH    = 1 << RAM_AW;
  localparam logic [3:0]  OFF_TMR_LO   = 4'd0;
  localparam logic [3:0]  OFF_TMR_HI   = 4'd1;
  localparam logic [3:0]  OFF_TMR_CTL  = 4'd2;
  localparam logic [3:0]  OFF_OUT_DAT  = 4'd3;
  localparam logic [3:0]  OFF_OUT_STAT = 4'd4;

  logic              is_ram;
  logic              is_io;
  logic              io_wr;
  logic [3:0]        io_off;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram [RAM_DEPTH];

  logic              out_vld;
  logic [7:0]        out_dat;
  logic              overrun;

  logic [7:0]        tmr_lo_rd;
  logic [7:0]        tmr_hi_rd;
  logic [7:0]        tmr_ctl_rd;

  // RAM takes priority should the I/O page ever overlap it.
  assign is_ram   = (bus.Address >> RAM_AW) == 16'd0;
  assign is_io    = !is_ram && (bus.Address[15:8] == IO_PAGE);
  assign io_off   = bus.Address[3:0];
  assign ram_addr = bus.Address[RAM_AW-1:0];
  assign io_wr    = bus.WE && is_io;

  always_ff @(posedge CLK) begin
    if (bus.WE && is_ram) begin
      ram[ram_addr] <= bus.DataIn;
    end
  end

  // A write while a byte is pending is accepted only if the sink takes the old byte on the same edge.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      out_vld <= 1'b0;
      out_dat <= 8'h00;
      overrun <= 1'b0;
    end else begin
      if (io_wr && io_off == OFF_OUT_DAT) begin
        if (!out_vld || bus.OUT_READY) begin
          out_dat <= bus.DataIn;
          out_vld <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_vld && bus.OUT_READY) begin
        out_vld <= 1'b0;
      end
      if (io_wr && io_off == OFF_OUT_STAT) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.OUT_VALID = out_vld;
  assign bus.OUT_DATA  = out_dat;

`ifdef MEM_IO_TARGET_TIMER_EN
  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  logic [15:0] reload, reload_nx;
  logic [15:0] counter, counter_nx;
  logic [7:0]  presc, presc_nx;
  logic        en, en_nx;
  logic        auto_rl, auto_nx;
  logic        irq_en, irq_en_nx;
  logic        flag, flag_nx;
  logic        irq_q;
  logic        tick;
  logic        underflow;

  assign tick      = en && (presc == PRESC_LAST);
  assign underflow = tick && (counter == 16'd0);

  // CPU writes are applied after the tick so they win; the underflow flag-set is applied last.
  always_comb begin
    reload_nx  = reload;
    counter_nx = counter;
    en_nx      = en;
    auto_nx    = auto_rl;
    irq_en_nx  = irq_en;
    flag_nx    = flag;
    if (tick) begin
      if (underflow) begin
        if (auto_rl) begin
          counter_nx = reload;
        end else begin
          en_nx = 1'b0;
        end
      end else begin
        counter_nx = counter - 16'd1;
      end
    end
    if (io_wr) begin
      case (io_off)
        OFF_TMR_LO: reload_nx[7:0] = bus.DataIn;
        OFF_TMR_HI: begin
          reload_nx[15:8] = bus.DataIn;
          counter_nx      = {bus.DataIn, reload[7:0]};
        end
        OFF_TMR_CTL: begin
          en_nx     = bus.DataIn[0];
          auto_nx   = bus.DataIn[1];
          irq_en_nx = bus.DataIn[2];
          if (bus.DataIn[7]) begin
            flag_nx = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (underflow) begin
      flag_nx = 1'b1;
    end
    // Prescaler restarts from 0 whenever the timer is (re)enabled.
    presc_nx = (en && en_nx && !tick) ? presc + 8'd1 : 8'd0;
  end

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      reload  <= 16'h0000;
      counter <= 16'h0000;
      presc   <= 8'h00;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      irq_en  <= 1'b0;
      flag    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      reload  <= reload_nx;
      counter <= counter_nx;
      presc   <= presc_nx;
      en      <= en_nx;
      auto_rl <= auto_nx;
      irq_en  <= irq_en_nx;
      flag    <= flag_nx;
      irq_q   <= flag & irq_en;
    end
  end

  assign bus.IRQ    = irq_q;
  assign tmr_lo_rd  = counter[7:0];
  assign tmr_hi_rd  = counter[15:8];
  assign tmr_ctl_rd = {flag, 4'b0000, irq_en, auto_rl, en};
`else
  assign bus.IRQ    = 1'b0;
  assign tmr_lo_rd  = 8'h00;
  assign tmr_hi_rd  = 8'h00;
  assign tmr_ctl_rd = 8'h00;
`endif

  // Read path is purely combinational: the CPU loops DataOut back into its next address.
  always_comb begin
    bus.DataOut = 8'hFF;
    if (is_ram) begin
      bus.DataOut = ram[ram_addr];
    end else if (is_io) begin
      case (io_off)
        OFF_TMR_LO:   bus.DataOut = tmr_lo_rd;
        OFF_TMR_HI:   bus.DataOut = tmr_hi_rd;
        OFF_TMR_CTL:  bus.DataOut = tmr_ctl_rd;
        OFF_OUT_DAT:  bus.DataOut = out_dat;
        OFF_OUT_STAT: bus.DataOut = {6'b000000, overrun, out_vld};
        default:      bus.DataOut = 8'h00;
      endcase
    end
  end

endmodule
